// File: rtl/key_pkg.sv
// Shared state encoding and millisecond timing helper for the key click classifier.
package key_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_WAIT2  = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_LONG   = 3'd4;

    function automatic int ms_to_cycles(input int freq_mhz, input int ms);
        return freq_mhz * 1000 * ms;
    endfunction

endpackage

// File: rtl/key_click_classifier_ms_timer.sv
// ms_timer: prescaler producing a 1 ms tick plus a saturating millisecond counter.
// Latency: ms_tick is decoded from the registered prescaler; clr takes effect on the next cycle.
// Backpressure: none; free-running whenever clr is low.
module ms_timer
    import key_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 100,
    parameter int MAX_MS       = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    output logic                          ms_tick,
    output logic [$clog2(MAX_MS+1)-1:0]   ms_cnt
);

    localparam int PRE_MAX = ms_to_cycles(CLK_FREQ_MHZ, 1) - 1;
    localparam int PRE_W   = $clog2(PRE_MAX + 1);
    localparam int CNT_W   = $clog2(MAX_MS + 1);

    logic [PRE_W-1:0] pre;

    assign ms_tick = (pre == PRE_W'(PRE_MAX));

    // Counter saturates so a long stay in one state never wraps into a false timeout.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pre    <= '0;
            ms_cnt <= '0;
        end else if (ms_tick) begin
            pre <= '0;
            if (ms_cnt != CNT_W'(MAX_MS)) begin
                ms_cnt <= ms_cnt + CNT_W'(1);
            end
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

endmodule

// File: rtl/key_click_classifier.sv
// key_click_classifier: turns debounced press/release pulses into click, double-click and long-press events.
// Latency: every output is registered; pulses appear the cycle after the triggering pulse or timeout.
// Backpressure: none; optional auto-repeat in LONG is built only when KEY_REPEAT_EN is defined.
module key_click_classifier
    import key_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 100,
    parameter int LONG_MS      = 1000,
    parameter int DOUBLE_MS    = 300,
    parameter int REPEAT_MS    = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic key_down_one_time,
    input  logic key_up_one_time,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic long_release,
    output logic long_hold,
    output logic key_repeat
);

    localparam int ST_MAX_MS = (LONG_MS > DOUBLE_MS) ? LONG_MS : DOUBLE_MS;
    localparam int ST_W      = $clog2(ST_MAX_MS + 1);
    localparam logic [ST_W-1:0] LONG_LAST = ST_W'(LONG_MS - 1);
    localparam logic [ST_W-1:0] DBL_LAST  = ST_W'(DOUBLE_MS - 1);

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic            st_tick;
    logic [ST_W-1:0] st_cnt;
    logic            down_ok;
    logic            up_ok;
    logic            press_tmo;
    logic            wait_tmo;
    logic            sc_nxt;
    logic            dc_nxt;
    logic            lp_nxt;
    logic            lr_nxt;

    // Simultaneous press and release is illegal upstream; neither is honoured.
    assign down_ok   = key_down_one_time & ~key_up_one_time;
    assign up_ok     = key_up_one_time & ~key_down_one_time;
    assign press_tmo = st_tick && (st_cnt == LONG_LAST);
    assign wait_tmo  = st_tick && (st_cnt == DBL_LAST);

    ms_timer #(
        .CLK_FREQ_MHZ(CLK_FREQ_MHZ),
        .MAX_MS      (ST_MAX_MS)
    ) u_state_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_nxt != state),
        .ms_tick(st_tick),
        .ms_cnt (st_cnt)
    );

    always_comb begin
        state_nxt = state;
        sc_nxt    = 1'b0;
        dc_nxt    = 1'b0;
        lp_nxt    = 1'b0;
        lr_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (down_ok) state_nxt = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (up_ok) begin
                    state_nxt = ST_WAIT2;
                end else if (press_tmo && !key_down_one_time) begin
                    state_nxt = ST_LONG;
                    lp_nxt    = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (down_ok) begin
                    state_nxt = ST_PRESS2;
                end else if (wait_tmo && !key_up_one_time) begin
                    state_nxt = ST_IDLE;
                    sc_nxt    = 1'b1;
                end
            end
            ST_PRESS2: begin
                if (up_ok) begin
                    state_nxt = ST_IDLE;
                    dc_nxt    = 1'b1;
                end
            end
            ST_LONG: begin
                if (up_ok) begin
                    state_nxt = ST_IDLE;
                    lr_nxt    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            long_release <= 1'b0;
            long_hold    <= 1'b0;
        end else begin
            state        <= state_nxt;
            single_click <= sc_nxt;
            double_click <= dc_nxt;
            long_press   <= lp_nxt;
            long_release <= lr_nxt;
            long_hold    <= (state_nxt == ST_LONG);
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RP_W = $clog2(REPEAT_MS + 1);
    localparam logic [RP_W-1:0] REP_LAST = RP_W'(REPEAT_MS - 1);

    logic            rp_tick;
    logic [RP_W-1:0] rp_cnt;
    logic            rp_fire;

    assign rp_fire = (state == ST_LONG) && rp_tick && (rp_cnt == REP_LAST);

    // Held in clear outside LONG so the first period starts exactly at LONG entry.
    ms_timer #(
        .CLK_FREQ_MHZ(CLK_FREQ_MHZ),
        .MAX_MS      (REPEAT_MS)
    ) u_repeat_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    ((state != ST_LONG) || rp_fire),
        .ms_tick(rp_tick),
        .ms_cnt (rp_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            key_repeat <= 1'b0;
        end else begin
            key_repeat <= rp_fire && (state_nxt == ST_LONG);
        end
    end
`else
    assign key_repeat = 1'b0;
`endif

endmodule
